// File: rtl/front_dispatch_queue_pkg.sv
// -----------------------------------------------------------------------------
// pkg_dtypes
// Shared datapath types for the front-end dispatch path.
//   type_iqueue_entry   : one renamed instruction as delivered by rename.
//   LOG2_NUM_EXEC_UNITS : width of an execution-unit index.
//   type_dispatch_batch : one full dispatch batch (lanes, lane valids and
//                         EU indices) at the default lane count.
// -----------------------------------------------------------------------------
package pkg_dtypes;

    localparam int LOG2_NUM_EXEC_UNITS   = 3;
    localparam int DEFAULT_DISPATCH_LANES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  prd;
        logic [6:0]  prs1;
        logic [6:0]  prs2;
    } type_iqueue_entry;

    typedef struct packed {
        type_iqueue_entry [DEFAULT_DISPATCH_LANES-1:0]                          lanes;
        logic             [DEFAULT_DISPATCH_LANES-1:0]                          valids;
        logic             [DEFAULT_DISPATCH_LANES-1:0][LOG2_NUM_EXEC_UNITS-1:0] euidx;
    } type_dispatch_batch;

endpackage

// File: rtl/front_dispatch_queue_batch_fifo.sv
// -----------------------------------------------------------------------------
// front_batch_fifo
// Generic first-word-fall-through FIFO: the head word is read combinationally
// from storage, so a written word shows at rdata_o the cycle after its push.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   push_i / wdata_i      : write request and data (ignored while full)
//   pop_i                 : drop the head word (ignored while empty)
//   rdata_o               : head word (undefined content while empty)
//   full_o / empty_o      : occupancy flags
// -----------------------------------------------------------------------------
module front_batch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra lap bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign rdata_o   = r_mem[r_rd_ptr[AW-1:0]];

    // Storage has no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/front_dispatch_queue.sv
// -----------------------------------------------------------------------------
// front_dispatch_queue
// Buffers renamed instruction batches between rename and the backend dispatch
// bus. Each batch (all lanes, lane valids, EU indices) is one queue entry.
// Batches with no valid lane are dropped. The head batch is presented
// combinationally and popped when the backend signals ready.
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset
//   instr_i / instr_valid_i        : incoming batch and per-lane valids
//   alloc_euidx_i                  : per-lane target execution unit
//   ready_o                        : queue can accept a batch (not full)
//   instr_dispatch_o               : head batch lanes (0 when empty)
//   instr_dispatch_valid_o         : head batch lane valids (0 when empty)
//   dispatched_instr_alloc_euidx_o : head batch EU indices (0 when empty)
//   instr_dispatch_ready_i         : backend accepts the presented batch
//   stall_count_o                  : only with FRONT_DISPATCH_STALL_CNT_EN;
//                                    saturating count of backpressured cycles
// Build option: define FRONT_DISPATCH_STALL_CNT_EN to add the stall counter.
// -----------------------------------------------------------------------------
module front_dispatch_queue
    import pkg_dtypes::*;
#(
    parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
    parameter int DEPTH                         = 4
) (
    input  logic                                                         clk,
    input  logic                                                         reset_n,
    input  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                          instr_i,
    input  logic             [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                          instr_valid_i,
    input  logic             [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0] alloc_euidx_i,
    output logic                                                         ready_o,
    output type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                          instr_dispatch_o,
    output logic             [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                          instr_dispatch_valid_o,
    output logic             [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_o,
    input  logic                                                         instr_dispatch_ready_i
`ifdef FRONT_DISPATCH_STALL_CNT_EN
    ,
    output logic [15:0]                                                  stall_count_o
`endif
);

    localparam int N       = NUM_PARALLEL_INSTR_DISPATCHES;
    localparam int LANE_W  = $bits(type_iqueue_entry);
    localparam int BATCH_W = N * (LANE_W + 1 + LOG2_NUM_EXEC_UNITS);

    logic [BATCH_W-1:0] w_wdata;
    logic [BATCH_W-1:0] w_rdata;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_head_active;

    type_iqueue_entry [N-1:0]                          w_head_lanes;
    logic             [N-1:0]                          w_head_valid;
    logic             [N-1:0][LOG2_NUM_EXEC_UNITS-1:0] w_head_euidx;

    assign w_wdata = {alloc_euidx_i, instr_valid_i, instr_i};
    assign {w_head_euidx, w_head_valid, w_head_lanes} = w_rdata;

    // ready_o depends only on stored occupancy, so a full queue refuses a
    // batch even in a cycle where the head is popped.
    assign ready_o       = !w_full;
    assign w_push        = ready_o && (|instr_valid_i);
    assign w_head_active = !w_empty && (|w_head_valid);
    assign w_pop         = w_head_active && instr_dispatch_ready_i;

    front_batch_fifo #(
        .WIDTH (BATCH_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_push),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .rdata_o (w_rdata),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Storage content is stale when empty; force every lane to zero then.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane_out
            assign instr_dispatch_o[gi]               = w_empty ? '0   : w_head_lanes[gi];
            assign instr_dispatch_valid_o[gi]         = w_empty ? 1'b0 : w_head_valid[gi];
            assign dispatched_instr_alloc_euidx_o[gi] = w_empty ? '0   : w_head_euidx[gi];
        end
    endgenerate

`ifdef FRONT_DISPATCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_head_active && !instr_dispatch_ready_i &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_count_o = r_stall_cnt;
`else
    // Stall instrumentation is not present in this build.
`endif

endmodule

// File: tb/tb_front_dispatch_queue.sv
module tb_front_dispatch_queue;
    import pkg_dtypes::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int EW = LOG2_NUM_EXEC_UNITS;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    type_iqueue_entry [N-1:0]         instr_i;
    logic             [N-1:0]         instr_valid_i;
    logic             [N-1:0][EW-1:0] alloc_euidx_i;
    logic                             ready_o;
    type_iqueue_entry [N-1:0]         instr_dispatch_o;
    logic             [N-1:0]         instr_dispatch_valid_o;
    logic             [N-1:0][EW-1:0] dispatched_instr_alloc_euidx_o;
    logic                             instr_dispatch_ready_i;
`ifdef FRONT_DISPATCH_STALL_CNT_EN
    logic [15:0] stall_count_o;
    int          stall_model = 0;
`endif

    front_dispatch_queue #(
        .NUM_PARALLEL_INSTR_DISPATCHES (N),
        .DEPTH                         (D)
    ) dut (
        .clk                            (clk),
        .reset_n                        (reset_n),
        .instr_i                        (instr_i),
        .instr_valid_i                  (instr_valid_i),
        .alloc_euidx_i                  (alloc_euidx_i),
        .ready_o                        (ready_o),
        .instr_dispatch_o               (instr_dispatch_o),
        .instr_dispatch_valid_o         (instr_dispatch_valid_o),
        .dispatched_instr_alloc_euidx_o (dispatched_instr_alloc_euidx_o),
        .instr_dispatch_ready_i         (instr_dispatch_ready_i)
`ifdef FRONT_DISPATCH_STALL_CNT_EN
        ,
        .stall_count_o                  (stall_count_o)
`endif
    );

    // Reference model: the queue of batches the backend must still receive.
    typedef struct {
        type_iqueue_entry [N-1:0]         lanes;
        logic             [N-1:0]         v;
        logic             [N-1:0][EW-1:0] eu;
    } batch_t;

    batch_t exp_q[$];
    int     total = 0;
    int     bad   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // One stimulus transaction per cycle: drive at negedge+1, check ready at
    // +2, record an accepted batch at +4 (after the monitor at +3).
    task automatic cycle(input logic [N-1:0] v, input logic rdy);
        batch_t b;
        logic   rdy_s;
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            b.lanes[i].pc    = $urandom;
            b.lanes[i].instr = $urandom;
            b.lanes[i].prd   = 7'($urandom_range(0, 127));
            b.lanes[i].prs1  = 7'($urandom_range(0, 127));
            b.lanes[i].prs2  = 7'($urandom_range(0, 127));
            b.eu[i]          = EW'($urandom_range(0, (1 << EW) - 1));
        end
        b.v                    = v;
        instr_i                = b.lanes;
        instr_valid_i          = v;
        alloc_euidx_i          = b.eu;
        instr_dispatch_ready_i = rdy;
        #1;
        check("ready_o", 512'(ready_o), 512'(exp_q.size() < D));
        rdy_s = ready_o;
        #2;
        if (rdy_s && (|v)) exp_q.push_back(b);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) cycle('0, 1'b1);
        check("drain_left", 512'(exp_q.size()), 512'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #6;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_ready_now", 512'(ready_o), 512'(1));
        check("rst_valid_now", 512'(instr_dispatch_valid_o), 512'(0));
        check("rst_data_now", 512'({dispatched_instr_alloc_euidx_o, instr_dispatch_o}), 512'(0));
        instr_valid_i = '0;
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [N-1:0] rand_nz();
        return N'($urandom_range(1, (1 << N) - 1));
    endfunction

    // Monitor: compares whatever the DUT presents against the model head.
    initial begin
        batch_t h;
        logic   busy;
        forever begin
            @(negedge clk);
            #3;
            busy = (exp_q.size() > 0);
            if (!reset_n) begin
                check("rst_valid", 512'(instr_dispatch_valid_o), 512'(0));
            end else if (!busy) begin
                check("empty_valid", 512'(instr_dispatch_valid_o), 512'(0));
                check("empty_data", 512'({dispatched_instr_alloc_euidx_o, instr_dispatch_o}), 512'(0));
            end else begin
                h = exp_q[0];
                check("head_lanes", 512'(instr_dispatch_o), 512'(h.lanes));
                check("head_valid", 512'(instr_dispatch_valid_o), 512'(h.v));
                check("head_euidx", 512'(dispatched_instr_alloc_euidx_o), 512'(h.eu));
                if (instr_dispatch_ready_i) void'(exp_q.pop_front());
            end
`ifdef FRONT_DISPATCH_STALL_CNT_EN
            if (!reset_n) stall_model = 0;
            check("stall_count", 512'(stall_count_o), 512'(stall_model));
            if (reset_n && busy && !instr_dispatch_ready_i && stall_model < 65535)
                stall_model++;
`endif
        end
    end

    initial begin
        instr_i                = '0;
        instr_valid_i          = '0;
        alloc_euidx_i          = '0;
        instr_dispatch_ready_i = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("init_ready", 512'(ready_o), 512'(1));
        check("init_valid", 512'(instr_dispatch_valid_o), 512'(0));
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Two-lane batch, backend ready: shows next cycle, popped, then empty.
        cycle(4'b0011, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);

        // Fill under backpressure; fifth push refused; then push+pop while full.
        repeat (5) cycle(rand_nz(), 1'b0);
        cycle(rand_nz(), 1'b1);
        drain();

        // Occupancy-1 steady state with simultaneous push and pop, wrapping.
        cycle(rand_nz(), 1'b0);
        repeat (10) cycle(rand_nz(), 1'b1);
        drain();

        // All-invalid batches are dropped.
        repeat (2) cycle('0, 1'b1);

        // Random traffic.
        repeat (400) begin
            logic [N-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? '0 : rand_nz();
            cycle(v, 1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Reset with three batches held.
        repeat (3) cycle(rand_nz(), 1'b0);
        do_reset();
        repeat (2) cycle('0, 1'b1);

`ifdef FRONT_DISPATCH_STALL_CNT_EN
        cycle(rand_nz(), 1'b0);
        repeat (70000) cycle('0, 1'b0);
        check("stall_sat", 512'(stall_count_o), 512'(16'hFFFF));
        do_reset();
        check("stall_after_rst", 512'(stall_count_o), 512'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/front_dispatch_queue.md
FRONT_DISPATCH_QUEUE -- requirements
Module: front_dispatch_queue

Interface
REQ-001 SHALL have parameter NUM_PARALLEL_INSTR_DISPATCHES, default 4, meaning dispatch lanes per batch; equals backend dispatch bus width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning batch entries held; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port instr_i  input  type_iqueue_entry[N]  renamed instruction batch from rename ILN.
REQ-006 SHALL have port instr_valid_i  input  1[N]  per-lane valid.
REQ-007 SHALL have port alloc_euidx_i  input  LOG2_NUM_EXEC_UNITS[N]  per-lane target EU index.
REQ-008 SHALL have port ready_o  output  1  queue can accept a batch.
REQ-009 SHALL have port instr_dispatch_o  output  type_iqueue_entry[N]  head batch to backend.
REQ-010 SHALL have port instr_dispatch_valid_o  output  1[N]  head batch lane valids.
REQ-011 SHALL have port dispatched_instr_alloc_euidx_o  output  LOG2_NUM_EXEC_UNITS[N]  head batch EU indices.
REQ-012 SHALL have port instr_dispatch_ready_i  input  1  backend accepted the presented batch.

Function
REQ-013 SHALL store each batch (all lanes, valids, EU indices) as one entry; push occurs when ready_o and any instr_valid_i lane is high.
REQ-014 SHALL drop a batch whose lanes are all invalid; no entry written.
REQ-015 SHALL drive ready_o = 1 when occupancy < DEPTH; at occupancy DEPTH ready_o = 0 even when a pop occurs that cycle (no full pass-through).
REQ-016 SHALL present the head entry combinationally from storage; pushed batch visible on outputs one cycle after the push edge (latency 1, no bypass).
REQ-017 SHALL pop the head when any head lane is valid and instr_dispatch_ready_i = 1; head outputs SHALL remain stable until popped.
REQ-018 SHALL drive instr_dispatch_valid_o all 0 when empty; data outputs then 0.
REQ-019 SHALL handle simultaneous push and pop with occupancy unchanged, including at occupancy 1 (new batch becomes head next cycle).
REQ-020 SHALL use read/write pointers of width log2(DEPTH)+1; wrap modulo DEPTH, full = pointers equal except MSB, empty = pointers equal.
REQ-021 SHALL ignore instr_dispatch_ready_i when empty.

Reset
REQ-022 SHALL, on reset_n low, asynchronously clear pointers and occupancy; ready_o = 1, instr_dispatch_valid_o all 0, data outputs 0.
REQ-023 SHALL discard all held batches on reset mid-operation; no partial batch emitted after reset release.

Configuration
REQ-024 SHALL, with FRONT_DISPATCH_STALL_CNT_EN defined, add output stall_count_o (16 bits) counting cycles where head valid and instr_dispatch_ready_i = 0, saturating at 0xFFFF, reset to 0.
REQ-025 SHALL, without FRONT_DISPATCH_STALL_CNT_EN, have no stall_count_o port and no counter logic; all other behaviour identical.

Structure
REQ-026 SHALL take type_iqueue_entry and LOG2_NUM_EXEC_UNITS from pkg_dtypes; new typedef type_dispatch_batch (lanes, valids, euidx) SHALL be added to pkg_dtypes.
REQ-027 SHALL implement storage as one sub-module front_batch_fifo (generic width/depth, push/pop/full/empty); top adds handshake, empty-batch drop and stall counter.

Verification
REQ-028 Reset then push batch lanes {A,B,-,-} valid 0011, ready_i=1 -> next cycle valid_o=0011, lanes A,B; popped that cycle; empty after.
REQ-029 ready_i=0, push 4 batches -> ready_o=0 after 4th; 5th push ignored; drain with ready_i=1 yields batches in order, ready_o=1 after first pop.
REQ-030 Full queue, push and pop same cycle -> ready_o stays 0 that cycle, incoming batch not stored, occupancy becomes 3.
REQ-031 Occupancy 1, simultaneous push and pop -> occupancy 1, new batch on outputs next cycle; pointers wrap past DEPTH cleanly over 10 batches.
REQ-032 Push all-invalid batch -> no entry; valid_o stays 0; reset asserted with 3 entries held -> outputs cleared immediately, ready_o=1.
REQ-033 With FRONT_DISPATCH_STALL_CNT_EN, hold head valid, ready_i=0 for 70000 cycles -> stall_count_o=0xFFFF; reset -> 0.
